// File: rtl/mc_ctrl_unit.sv
// Multi-cycle control unit: steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
// It drives the fetch/datapath strobes and handles a data-memory wait with timeout.
module mc_ctrl_unit #(
    parameter int MEM_WAIT_MAX = 15,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      inst,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             ct_branch,
    output logic             ct_jump,
    output logic             reg_we,
    output logic [1:0]       reg_dst,
    output logic             alu_src,
    output logic             imm_zext,
    output logic [2:0]       alu_op,
    output logic             mem_re,
    output logic             mem_we,
    output logic [1:0]       wb_sel,
    output logic [31:0]      ir,
    output logic [2:0]       state,
    output logic             illegal,
    output logic             mem_err,
    output logic [CNT_W-1:0] retired_cnt
);
    typedef enum logic [2:0] {
        S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
        S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd7
    } state_t;

    localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2,
                           OP_OR = 3'd3, OP_SLT = 3'd4, OP_LUI = 3'd5;
    localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

    state_t     st;
    logic [7:0] wait_cnt;

    logic [5:0] op, funct;
    logic       is_r, r_ok, is_addi, is_andi, is_ori, is_lui;
    logic       is_lw, is_sw, is_beq, is_j, is_jal, legal;
    logic [2:0] dec_op;
    logic       dec_src, dec_zext;

    assign op      = ir[31:26];
    assign funct   = ir[5:0];
    assign is_r    = (op == 6'b000000);
    assign r_ok    = is_r && (funct == 6'b100000 || funct == 6'b100010 ||
                              funct == 6'b100100 || funct == 6'b100101 ||
                              funct == 6'b101010);
    assign is_addi = (op == 6'b001000);
    assign is_andi = (op == 6'b001100);
    assign is_ori  = (op == 6'b001101);
    assign is_lui  = (op == 6'b001111);
    assign is_lw   = (op == 6'b100011);
    assign is_sw   = (op == 6'b101011);
    assign is_beq  = (op == 6'b000100);
    assign is_j    = (op == 6'b000010);
    assign is_jal  = (op == 6'b000011);
    assign legal   = r_ok | is_addi | is_andi | is_ori | is_lui |
                     is_lw | is_sw | is_beq | is_j | is_jal;
    assign state   = st;

    always_comb begin
        dec_op   = OP_ADD;
        dec_src  = 1'b1;
        dec_zext = 1'b0;
        if (is_r) begin
            dec_src = 1'b0;
            case (funct)
                6'b100010: dec_op = OP_SUB;
                6'b100100: dec_op = OP_AND;
                6'b100101: dec_op = OP_OR;
                6'b101010: dec_op = OP_SLT;
                default:   dec_op = OP_ADD;
            endcase
        end else if (is_beq) begin
            dec_op  = OP_SUB;
            dec_src = 1'b0;
        end else if (is_andi) begin
            dec_op   = OP_AND;
            dec_zext = 1'b1;
        end else if (is_ori) begin
            dec_op   = OP_OR;
            dec_zext = 1'b1;
        end else if (is_lui) begin
            dec_op = OP_LUI;
        end
    end

    // Strobes depend only on registered state/ir (plus mem_ready for the sw handshake).
    always_comb begin
        pc_en     = 1'b0;
        ct_branch = 1'b0;
        ct_jump   = 1'b0;
        reg_we    = 1'b0;
        reg_dst   = 2'd0;
        alu_src   = 1'b0;
        imm_zext  = 1'b0;
        alu_op    = OP_ADD;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        wb_sel    = 2'd0;
        case (st)
            S_DECODE: begin
                if (is_j || is_jal) begin
                    pc_en   = 1'b1;
                    ct_jump = 1'b1;
                end
                if (is_jal) begin
                    reg_we  = 1'b1;
                    reg_dst = 2'd2;
                    wb_sel  = 2'd2;
                end
            end
            S_EXEC, S_MEM, S_WB: begin
                alu_op   = dec_op;
                alu_src  = dec_src;
                imm_zext = dec_zext;
                if (st == S_EXEC && is_beq) begin
                    ct_branch = 1'b1;
                    pc_en     = 1'b1;
                end
                if (st == S_MEM) begin
                    mem_re = is_lw;
                    mem_we = is_sw;
                    pc_en  = is_sw && mem_ready;
                end
                if (st == S_WB) begin
                    reg_we  = 1'b1;
                    pc_en   = 1'b1;
                    reg_dst = is_r ? 2'd1 : 2'd0;
                    wb_sel  = is_lw ? 2'd1 : 2'd0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st          <= S_FETCH;
            ir          <= '0;
            wait_cnt    <= '0;
            illegal     <= 1'b0;
            mem_err     <= 1'b0;
            retired_cnt <= '0;
        end else begin
            if (pc_en) retired_cnt <= retired_cnt + CNT_W'(1);
            case (st)
                S_FETCH: begin
                    ir <= inst;
                    st <= S_DECODE;
                end
                S_DECODE: begin
                    if (!legal) begin
                        illegal <= 1'b1;
                        st      <= S_HALT;
                    end else if (is_j || is_jal) st <= S_FETCH;
                    else st <= S_EXEC;
                end
                S_EXEC: begin
                    if (is_beq) st <= S_FETCH;
                    else if (is_lw || is_sw) st <= S_MEM;
                    else st <= S_WB;
                end
                S_MEM: begin
                    // A ready in the final allowed cycle still completes the access.
                    if (mem_ready) begin
                        wait_cnt <= '0;
                        st       <= is_lw ? S_WB : S_FETCH;
                    end else if (wait_cnt == WAIT_LAST) begin
                        wait_cnt <= '0;
                        mem_err  <= 1'b1;
                        st       <= S_HALT;
                    end else wait_cnt <= wait_cnt + 8'd1;
                end
                S_WB:    st <= S_FETCH;
                S_HALT:  st <= S_HALT;
                default: st <= S_HALT;
            endcase
        end
    end
endmodule

// File: tb/tb_mc_ctrl_unit.sv
// Directed bench for mc_ctrl_unit: a vector table of instructions with expected latency,
// state trace and strobes, plus hand sequences for timeout, illegal, counter wrap and reset aborts.
module tb_mc_ctrl_unit;
    logic        clk = 1'b0, rst = 1'b1;
    logic [31:0] inst = '0;
    logic        mem_ready = 1'b0;
    logic        pc_en, ct_branch, ct_jump, reg_we, alu_src, imm_zext, mem_re, mem_we;
    logic        illegal, mem_err;
    logic [1:0]  reg_dst, wb_sel;
    logic [2:0]  alu_op, state;
    logic [31:0] ir;
    logic [3:0]  retired_cnt;
    logic [14:0] ov;
    logic [3:0]  model_cnt;
    int checks = 0, errors = 0;

    mc_ctrl_unit #(.MEM_WAIT_MAX(15), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .inst(inst), .mem_ready(mem_ready),
        .pc_en(pc_en), .ct_branch(ct_branch), .ct_jump(ct_jump), .reg_we(reg_we),
        .reg_dst(reg_dst), .alu_src(alu_src), .imm_zext(imm_zext), .alu_op(alu_op),
        .mem_re(mem_re), .mem_we(mem_we), .wb_sel(wb_sel), .ir(ir), .state(state),
        .illegal(illegal), .mem_err(mem_err), .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;
    assign ov = {pc_en, ct_branch, ct_jump, reg_we, reg_dst, alu_src, imm_zext,
                 alu_op, mem_re, mem_we, wb_sel};

    typedef struct {
        logic [31:0] inst;
        int          waits;
        int          lat;
        logic [31:0] seq;
        logic [14:0] ov;
        int          memc;
    } vec_t;

    function automatic logic [14:0] mkov(logic br, logic jm, logic we, logic [1:0] dst,
                                         logic src, logic zx, logic [2:0] alu,
                                         logic re, logic wm, logic [1:0] wb);
        return {1'b1, br, jm, we, dst, src, zx, alu, re, wm, wb};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        model_cnt = '0;
    endtask

    // Called while the next cycle is FETCH; returns just after the posedge ending the pc_en cycle.
    task automatic run(input vec_t v, input int idx);
        int c, mc;
        logic [31:0] seq;
        logic [14:0] snap;
        bit done;
        inst = v.inst; mem_ready = 1'b0;
        c = 0; mc = 0; seq = '0; snap = '0; done = 0;
        while (!done && c < 40) begin
            @(negedge clk);
            c++;
            mem_ready = (state == 3'd3) && (mc >= v.waits);
            #1;
            if (c == 1) chk($sformatf("fetch%0d", idx), state, 3'd0);
            seq = {seq[27:0], 1'b0, state};
            if (mem_re || mem_we) mc++;
            chk($sformatf("excl%0d", idx),
                (ct_branch & ct_jump) | ((ct_branch | ct_jump) & ~pc_en), 1'b0);
            if (pc_en) begin
                done = 1;
                snap = ov;
            end
        end
        model_cnt = model_cnt + 4'd1;
        chk($sformatf("lat%0d", idx), c, v.lat);
        chk($sformatf("seq%0d", idx), seq, v.seq);
        chk($sformatf("outs%0d", idx), snap, v.ov);
        chk($sformatf("memc%0d", idx), mc, v.memc);
        @(posedge clk);
        #1 mem_ready = 1'b0;
        chk($sformatf("cnt%0d", idx), retired_cnt, model_cnt);
    endtask

    vec_t tbl[15];

    initial begin
        int k, mc, pe;
        tbl[0]  = '{32'h012A4020, 0, 4, 32'h0124, mkov(0,0,1,2'd1,0,0,3'd0,0,0,2'd0), 0};
        tbl[1]  = '{32'h012A4022, 0, 4, 32'h0124, mkov(0,0,1,2'd1,0,0,3'd1,0,0,2'd0), 0};
        tbl[2]  = '{32'h012A4024, 0, 4, 32'h0124, mkov(0,0,1,2'd1,0,0,3'd2,0,0,2'd0), 0};
        tbl[3]  = '{32'h012A4025, 0, 4, 32'h0124, mkov(0,0,1,2'd1,0,0,3'd3,0,0,2'd0), 0};
        tbl[4]  = '{32'h012A402A, 0, 4, 32'h0124, mkov(0,0,1,2'd1,0,0,3'd4,0,0,2'd0), 0};
        tbl[5]  = '{32'h21090005, 0, 4, 32'h0124, mkov(0,0,1,2'd0,1,0,3'd0,0,0,2'd0), 0};
        tbl[6]  = '{32'h3109FFFF, 0, 4, 32'h0124, mkov(0,0,1,2'd0,1,1,3'd2,0,0,2'd0), 0};
        tbl[7]  = '{32'h3509FFFF, 0, 4, 32'h0124, mkov(0,0,1,2'd0,1,1,3'd3,0,0,2'd0), 0};
        tbl[8]  = '{32'h3C091234, 0, 4, 32'h0124, mkov(0,0,1,2'd0,1,0,3'd5,0,0,2'd0), 0};
        // lw with 3 wait cycles: 3 cycles + 4 MEM cycles + WB = 8 cycles inclusive
        tbl[9]  = '{32'h8D090004, 3, 8, 32'h01233334, mkov(0,0,1,2'd0,1,0,3'd0,0,0,2'd1), 4};
        tbl[10] = '{32'hAD090004, 2, 6, 32'h00012333, mkov(0,0,0,2'd0,1,0,3'd0,0,1,2'd0), 3};
        // ready on the last allowed MEM cycle still completes
        tbl[11] = '{32'hAD090004, 14, 18, 32'h33333333, mkov(0,0,0,2'd0,1,0,3'd0,0,1,2'd0), 15};
        tbl[12] = '{32'h11090003, 0, 3, 32'h012, mkov(1,0,0,2'd0,0,0,3'd1,0,0,2'd0), 0};
        tbl[13] = '{32'h08000010, 0, 2, 32'h01, mkov(0,1,0,2'd0,0,0,3'd0,0,0,2'd0), 0};
        tbl[14] = '{32'h0C000010, 0, 2, 32'h01, mkov(0,1,1,2'd2,0,0,3'd0,0,0,2'd2), 0};

        // reset state, with a nonzero instruction presented
        inst = 32'hFFFFFFFF;
        #12;
        chk("rst_state", state, 3'd0);
        chk("rst_outs", ov, 15'd0);
        chk("rst_ir", ir, 32'd0);
        chk("rst_flags", {illegal, mem_err, retired_cnt}, 6'd0);
        do_reset();

        for (int i = 0; i < 15; i++) run(tbl[i], i);

        // illegal opcode halts; async reset mid-halt clears everything
        inst = 32'hFC000000;
        step(); chk("ill_fetch", state, 3'd0);
        step(); chk("ill_dec_pc", pc_en, 1'b0);
        step(); chk("ill_state", state, 3'd7);
        chk("ill_flag", illegal, 1'b1);
        chk("ill_cnt_held", retired_cnt, model_cnt);
        step(); step(); chk("ill_stay", {state, ov}, {3'd7, 15'd0});
        #2 rst = 1'b1;
        #1 chk("rst_halt", {state, illegal, retired_cnt}, 8'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_cnt = '0;

        // unsupported R-type funct (addu)
        inst = 32'h012A4021;
        step(); step(); step();
        chk("ill_funct", {state, illegal}, {3'd7, 1'b1});
        do_reset();

        // sw timeout: mem_ready stays low
        inst = 32'hAD090004;
        mc = 0; pe = 0;
        for (k = 0; k < 40; k++) begin
            step();
            if (mem_we) mc++;
            if (pc_en) pe++;
            if (state == 3'd7) break;
        end
        chk("to_state", state, 3'd7);
        chk("to_memc", mc, 15);
        chk("to_err", mem_err, 1'b1);
        chk("to_no_pc", pe, 0);
        mem_ready = 1'b1;
        step(); step(); step();
        chk("to_stay", {state, ov, mem_err}, {3'd7, 15'd0, 1'b1});
        chk("to_cnt", retired_cnt, 4'd0);
        do_reset();

        // counter wrap with CNT_W=4
        for (int i = 0; i < 15; i++) run(tbl[13], 100 + i);
        chk("wrap15", retired_cnt, 4'd15);
        run(tbl[13], 115);
        chk("wrap0", retired_cnt, 4'd0);

        // reset mid-MEM of lw aborts with no pc_en
        run(tbl[13], 200);
        inst = 32'h8D090004;
        step(); step(); step(); step();
        chk("ab_mem", {state, mem_re}, {3'd3, 1'b1});
        #2 rst = 1'b1;
        #1 chk("ab_outs", ov, 15'd0);
        chk("ab_state", {state, retired_cnt}, 7'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
